fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares one fifo_single_clock write port between N producers.
- Each producer has a valid/ready handshake. The winner's word is registered, tagged with its source index and written into the FIFO one cycle later.
- Grants are throttled from the FIFO's full/count flags, so the FIFO overflow flag never asserts in normal operation.
- Supports bounded bursts: a source keeps priority for up to MAX_BURST consecutive grants.

---
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N valid/ready producers share one FIFO write port.
// The winning word is registered with its source tag and presented to the FIFO one cycle later.
module fifo_wr_arbiter #(
    parameter  int N         = 4,
    parameter  int DW        = 32,
    parameter  int DEPTH     = 32,
    parameter  int MAX_BURST = 2,
    localparam int TW        = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int CW        = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             enable_i,
    input  logic [N-1:0]     src_valid_i,
    input  logic [N*DW-1:0]  src_data_i,
    output logic [N-1:0]     src_ready_o,
    output logic             fifo_valid_o,
    output logic [TW+DW-1:0] fifo_data_o,
    input  logic             fifo_full_i,
    input  logic [CW-1:0]    fifo_count_i,
    output logic [TW-1:0]    grant_idx_o
);

    localparam int BW = $clog2(MAX_BURST + 1);

    // Handshake: source k transfers on a cycle where src_valid_i[k] && src_ready_o[k];
    // the source must hold valid and data stable until that cycle. src_ready_o is one-hot or zero.

    logic [TW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic             fifo_valid_q, fifo_valid_d;
    logic [TW+DW-1:0] fifo_data_q, fifo_data_d;
    logic [TW-1:0]    grant_idx_q, grant_idx_d;

    logic [DW-1:0]    src_word [N];
    logic [CW:0]      fill_sum;
    logic             space_ok;
    logic             arb_ok;
    logic             cont;
    logic             rot_found;
    logic [TW-1:0]    rot_idx;
    logic             grant;
    logic [TW-1:0]    win;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            src_word[k] = src_data_i[k*DW +: DW];
        end
    end

    // One slot of headroom covers the word already registered but not yet counted by the FIFO.
    always_comb begin
        fill_sum = {1'b0, fifo_count_i} + {{CW{1'b0}}, fifo_valid_q};
        space_ok = !fifo_full_i && (fill_sum <= (CW+1)'(DEPTH - 2));
        arb_ok   = enable_i && space_ok && !srst_i;
    end

    always_comb begin
        cont = arb_ok && (burst_q != '0) && (burst_q < BW'(MAX_BURST)) && src_valid_i[owner_q];

        // Walk downward so the candidate closest after the owner is the one left standing.
        rot_found = 1'b0;
        rot_idx   = owner_q;
        for (int i = N; i >= 1; i--) begin
            if (src_valid_i[TW'((int'(owner_q) + i) % N)]) begin
                rot_found = 1'b1;
                rot_idx   = TW'((int'(owner_q) + i) % N);
            end
        end

        grant = cont || (arb_ok && rot_found);
        win   = cont ? owner_q : rot_idx;

        src_ready_o = '0;
        if (grant) begin
            src_ready_o[win] = 1'b1;
        end
    end

    always_comb begin
        owner_d      = owner_q;
        burst_d      = burst_q;
        fifo_valid_d = grant;
        fifo_data_d  = fifo_data_q;
        grant_idx_d  = grant_idx_q;

        if (cont) begin
            burst_d = burst_q + BW'(1);
        end else if (grant) begin
            owner_d = win;
            burst_d = BW'(1);
        end else if (arb_ok) begin
            burst_d = '0;
        end

        if (grant) begin
            fifo_data_d = {win, src_word[win]};
            grant_idx_d = win;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            owner_q      <= TW'(N - 1);
            burst_q      <= '0;
            fifo_valid_q <= 1'b0;
            fifo_data_q  <= '0;
            grant_idx_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            burst_q      <= burst_d;
            fifo_valid_q <= fifo_valid_d;
            fifo_data_q  <= fifo_data_d;
            grant_idx_q  <= grant_idx_d;
        end
    end

    assign fifo_valid_o = fifo_valid_q;
    assign fifo_data_o  = fifo_data_q;
    assign grant_idx_o  = grant_idx_q;

endmodule
